crc_comparator: RTL and testbench

CRC_COMPARATOR -- requirements
Module: crc_comparator

---
 rtl/crc_comparator_pkg.sv | 22 ++
 rtl/crc_comparator_vote.sv | 35 +++
 rtl/crc_comparator.sv | 195 +++++++++++++++++++
 tb/tb_crc_comparator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/crc_comparator_pkg.sv
// Shared CRC defines for the comparator: key/address/data widths and the
// comparator FSM state encoding.
package crc_comparator_pkg;

    localparam int CRC_KEY_WIDTH         = 8;
    localparam int CRC_RAM_ADDRESS_WIDTH = 10;
    localparam int CRC_WIDTH             = 32;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LATCH    = 4'd1,
        RD0      = 4'd2,
        RD1      = 4'd3,
        RD2      = 4'd4,
        CMP      = 4'd5,
        INC      = 4'd6,
        WAIT_ACK = 4'd7,
        DONE     = 4'd8,
        RST_TASK = 4'd9
    } state_t;

endpackage

// File: rtl/crc_comparator_vote.sv
// crc_vote: three-way CRC equality / majority vote. Reports which single core
// disagrees with the other two, or 3 when no two cores agree.
module crc_vote
    import crc_comparator_pkg::*;
(
    input  logic [CRC_WIDTH-1:0] a,
    input  logic [CRC_WIDTH-1:0] b,
    input  logic [CRC_WIDTH-1:0] c,
    output logic                 mismatch,
    output logic [1:0]           odd_core
);

    logic ab, bc, ac;

    assign ab = (a == b);
    assign bc = (b == c);
    assign ac = (a == c);

    // Pick the outlier core from the pairwise equalities.
    always_comb begin
        mismatch = 1'b1;
        odd_core = 2'd3;
        if (ab && bc) begin
            mismatch = 1'b0;
            odd_core = 2'd0;
        end else if (ab) begin
            odd_core = 2'd2;
        end else if (ac) begin
            odd_core = 2'd1;
        end else if (bc) begin
            odd_core = 2'd0;
        end
    end

endmodule

// File: rtl/crc_comparator.sv
// crc_comparator: reads the oldest CRC of a task from each core's queue,
// votes (TMR) or compares (DMR), advances the tails and reports the result.
// Optional feature macro: CRC_COMP_RESET_ON_MISMATCH_EN -- a mismatch resets
// the task instead of advancing the tails.
module crc_comparator
    import crc_comparator_pkg::*;
#(
    parameter int TAIL_ACK_TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             check_req,
    input  logic [CRC_KEY_WIDTH-1:0]         check_task_id,
    input  logic                             check_tmr,
    output logic [CRC_KEY_WIDTH-1:0]         comparator_task_id,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_head_pointer_0,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_head_pointer_1,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_head_pointer_2,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer_0,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer_1,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer_2,
    output logic                             comparator_inc_tail_pointer,
    output logic                             comparator_reset_task,
    input  logic                             comp_inc_tail_pointer_ack,
    output logic                             ram_rd_en,
    output logic [CRC_RAM_ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [1:0]                       ram_rd_core,
    input  logic [CRC_WIDTH-1:0]             ram_rd_data,
    output logic                             result_valid,
    output logic                             result_empty,
    output logic                             result_mismatch,
    output logic                             result_timeout,
    output logic [1:0]                       result_core,
    output logic [CRC_KEY_WIDTH-1:0]         result_task_id
);

    localparam int CNT_W = (TAIL_ACK_TIMEOUT > 1) ? $clog2(TAIL_ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAIL_ACK_TIMEOUT - 1);

    state_t               state, state_next;
    logic                 tmr;
    logic                 empty;
    logic [CRC_WIDTH-1:0] data_0, data_1;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 pend_mismatch;
    logic [1:0]           pend_core;
    logic                 vote_mismatch;
    logic [1:0]           vote_core;
    logic                 cmp_mismatch;
    logic [1:0]           cmp_core;
    logic                 queue_empty;
    logic                 commit, fin_empty, fin_timeout;

    // Core 2 data is compared straight off the RAM port in the cycle it lands.
    crc_vote u_vote (
        .a        (data_0),
        .b        (data_1),
        .c        (ram_rd_data),
        .mismatch (vote_mismatch),
        .odd_core (vote_core)
    );

    assign cmp_mismatch = tmr ? vote_mismatch : (data_0 != data_1);
    assign cmp_core     = tmr ? vote_core : (cmp_mismatch ? 2'd3 : 2'd0);

    assign queue_empty = (comp_head_pointer_0 == comp_tail_pointer_0) ||
                         (comp_head_pointer_1 == comp_tail_pointer_1) ||
                         (tmr && (comp_head_pointer_2 == comp_tail_pointer_2));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state; commit marks the transition into DONE.
    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        fin_empty   = 1'b0;
        fin_timeout = 1'b0;
        case (state)
            IDLE:     if (check_req) state_next = LATCH;
            LATCH:    state_next = RD0;
            RD0: begin
                if (empty) begin
                    state_next = DONE;
                    commit     = 1'b1;
                    fin_empty  = 1'b1;
                end else begin
                    state_next = RD1;
                end
            end
            RD1:      state_next = RD2;
            RD2:      state_next = CMP;
            CMP: begin
`ifdef CRC_COMP_RESET_ON_MISMATCH_EN
                state_next = cmp_mismatch ? RST_TASK : INC;
`else
                state_next = INC;
`endif
            end
            RST_TASK: begin
                state_next = DONE;
                commit     = 1'b1;
            end
            INC:      state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (comp_inc_tail_pointer_ack) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    state_next  = DONE;
                    commit      = 1'b1;
                    fin_timeout = 1'b1;
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode; the pointer compare in LATCH is registered and acted on in RD0.
    always_comb begin
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        ram_rd_core = 2'd0;
        case (state)
            RD0: begin
                ram_rd_en   = !empty;
                ram_rd_addr = comp_tail_pointer_0;
            end
            RD1: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = comp_tail_pointer_1;
                ram_rd_core = 2'd1;
            end
            RD2: begin
                ram_rd_en   = tmr;
                ram_rd_addr = tmr ? comp_tail_pointer_2 : '0;
                ram_rd_core = tmr ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
    end

    assign comparator_inc_tail_pointer = (state == INC);
    assign comparator_reset_task       = (state == RST_TASK);
    assign result_valid                = (state == DONE);

    // Request latch, empty flag, data capture and ack timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comparator_task_id <= '0;
            tmr                <= 1'b0;
            empty              <= 1'b0;
            data_0             <= '0;
            data_1             <= '0;
            wait_cnt           <= '0;
            pend_mismatch      <= 1'b0;
            pend_core          <= 2'd0;
        end else begin
            if (state == IDLE && check_req) begin
                comparator_task_id <= check_task_id;
                tmr                <= check_tmr;
            end
            if (state == LATCH) empty  <= queue_empty;
            if (state == RD1)   data_0 <= ram_rd_data;
            if (state == RD2)   data_1 <= ram_rd_data;
            if (state == CMP) begin
                pend_mismatch <= cmp_mismatch;
                pend_core     <= cmp_core;
            end
            wait_cnt <= (state == WAIT_ACK) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Result fields update only on entry to DONE and hold until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_empty    <= 1'b0;
            result_mismatch <= 1'b0;
            result_timeout  <= 1'b0;
            result_core     <= 2'd0;
            result_task_id  <= '0;
        end else if (commit) begin
            result_empty    <= fin_empty;
            result_timeout  <= fin_timeout;
            result_mismatch <= fin_empty ? 1'b0 : pend_mismatch;
            result_core     <= fin_empty ? 2'd0 : pend_core;
            result_task_id  <= comparator_task_id;
        end
    end

endmodule

// File: tb/tb_crc_comparator.sv
// Table-driven bench for crc_comparator with a behavioural RAM (1-cycle read)
// and a tail-pointer block that acks a configurable number of cycles after INC.
module tb_crc_comparator;
    import crc_comparator_pkg::*;

`ifdef CRC_COMP_RESET_ON_MISMATCH_EN
    localparam bit RST_ON_MIS = 1'b1;
`else
    localparam bit RST_ON_MIS = 1'b0;
`endif
    localparam int MIS_LAT = RST_ON_MIS ? 7 : 8;
    localparam int MIS_INC = RST_ON_MIS ? 0 : 1;
    localparam int MIS_RST = RST_ON_MIS ? 1 : 0;

    typedef struct {
        string       name;
        bit          tmr;
        logic [7:0]  task_id;
        logic [2:0][9:0]  tail;
        logic [2:0][9:0]  head;
        logic [2:0][31:0] data;
        int          ack_delay;  // 0 = never ack
        int          alt_cyc;    // cycle at which a different task id is shown
        bit          e_empty, e_mis, e_to;
        logic [1:0]  e_core;
        int          e_lat, e_inc, e_rst, e_reads;
    } vec_t;

    logic clk = 0, reset = 0;
    logic check_req = 0, check_tmr = 0, ack = 0;
    logic [7:0] check_task_id = 0;
    logic [9:0] h0 = 0, h1 = 0, h2 = 0, t0 = 0, t1 = 0, t2 = 0;
    logic [31:0] rd_data = 0;
    logic [7:0] cmp_task, res_task;
    logic inc, rst_task, rd_en, r_valid, r_empty, r_mis, r_to;
    logic [9:0] rd_addr;
    logic [1:0] rd_core, r_core;

    int pass_cnt = 0, total_cnt = 0;
    int inc_cnt = 0, rst_cnt = 0, rd_cnt = 0, ack_wait = 0;
    bit pend_vld = 0;
    logic [31:0] pend_data = 0;
    vec_t cur;
    vec_t vecs[12];

    crc_comparator #(.TAIL_ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .check_req(check_req), .check_task_id(check_task_id), .check_tmr(check_tmr),
        .comparator_task_id(cmp_task),
        .comp_head_pointer_0(h0), .comp_head_pointer_1(h1), .comp_head_pointer_2(h2),
        .comp_tail_pointer_0(t0), .comp_tail_pointer_1(t1), .comp_tail_pointer_2(t2),
        .comparator_inc_tail_pointer(inc), .comparator_reset_task(rst_task),
        .comp_inc_tail_pointer_ack(ack),
        .ram_rd_en(rd_en), .ram_rd_addr(rd_addr), .ram_rd_core(rd_core), .ram_rd_data(rd_data),
        .result_valid(r_valid), .result_empty(r_empty), .result_mismatch(r_mis),
        .result_timeout(r_to), .result_core(r_core), .result_task_id(res_task)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // RAM and tail-pointer block models, stepped on the falling edge.
    always @(negedge clk) begin
        rd_data  = pend_vld ? pend_data : 32'h0BAD_0BAD;
        pend_vld = 0;
        if (rd_en) begin
            chk("rd_order", 64'(rd_core), 64'(rd_cnt));
            chk("rd_addr", 64'(rd_addr),
                64'(rd_core == 2'd0 ? cur.tail[0] : rd_core == 2'd1 ? cur.tail[1] : cur.tail[2]));
            pend_data = (rd_core == 2'd0) ? cur.data[0] : (rd_core == 2'd1) ? cur.data[1] : cur.data[2];
            pend_vld  = 1;
            rd_cnt++;
        end
        ack = 0;
        if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) ack = 1;
        end
        if (inc) begin
            inc_cnt++;
            ack_wait = cur.ack_delay;
        end
        if (rst_task) rst_cnt++;
    end

    function automatic vec_t mk(input string nm, input bit tmr, input logic [7:0] tid,
                                input logic [2:0][9:0] tl, input logic [2:0][9:0] hd,
                                input logic [2:0][31:0] dt, input int ackd, input int alt,
                                input bit emp, input bit mis, input logic [1:0] core, input bit to,
                                input int lat, input int incs, input int rsts, input int reads);
        vec_t v;
        v.name = nm; v.tmr = tmr; v.task_id = tid; v.tail = tl; v.head = hd; v.data = dt;
        v.ack_delay = ackd; v.alt_cyc = alt; v.e_empty = emp; v.e_mis = mis; v.e_core = core;
        v.e_to = to; v.e_lat = lat; v.e_inc = incs; v.e_rst = rsts; v.e_reads = reads;
        return v;
    endfunction

    task automatic apply_inputs(input vec_t v);
        cur = v;
        inc_cnt = 0; rst_cnt = 0; rd_cnt = 0; ack_wait = 0;
        t0 = v.tail[0]; t1 = v.tail[1]; t2 = v.tail[2];
        h0 = v.head[0]; h1 = v.head[1]; h2 = v.head[2];
        check_tmr = v.tmr; check_task_id = v.task_id; check_req = 1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat = 0;
        bit seen = 0;
        @(negedge clk);
        apply_inputs(v);
        @(posedge clk);
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            check_task_id = (lat == v.alt_cyc) ? 8'h99 : v.task_id;
            if (r_valid) seen = 1;
        end
        check_req = 0;
        chk({v.name, ".valid_seen"}, 64'(seen), 64'd1);
        chk({v.name, ".latency"}, 64'(lat), 64'(v.e_lat));
        chk({v.name, ".empty"}, 64'(r_empty), 64'(v.e_empty));
        chk({v.name, ".mismatch"}, 64'(r_mis), 64'(v.e_mis));
        chk({v.name, ".core"}, 64'(r_core), 64'(v.e_core));
        chk({v.name, ".timeout"}, 64'(r_to), 64'(v.e_to));
        chk({v.name, ".task"}, 64'(res_task), 64'(v.task_id));
        @(negedge clk);
        chk({v.name, ".valid_pulse"}, 64'(r_valid), 64'd0);
        chk({v.name, ".task_hold"}, 64'(res_task), 64'(v.task_id));
        chk({v.name, ".inc_pulses"}, 64'(inc_cnt), 64'(v.e_inc));
        chk({v.name, ".rst_pulses"}, 64'(rst_cnt), 64'(v.e_rst));
        chk({v.name, ".reads"}, 64'(rd_cnt), 64'(v.e_reads));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("tmr_match", 1, 8'd5, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, 1, 0, 0, 0, 2'd0, 0, 8, 1, 0, 3);
        vecs[1]  = mk("tmr_core1", 1, 8'd6, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D}, 1, 0, 0, 1, 2'd1, 0, MIS_LAT, MIS_INC, MIS_RST, 3);
        vecs[2]  = mk("tmr_core0", 1, 8'd7, {10'h003, 10'h002, 10'h001}, {10'h004, 10'h003, 10'h002},
                      {32'h11111111, 32'h11111111, 32'h22222222}, 1, 0, 0, 1, 2'd0, 0, MIS_LAT, MIS_INC, MIS_RST, 3);
        vecs[3]  = mk("tmr_core2", 1, 8'd8, {10'h3FF, 10'h200, 10'h100}, {10'h000, 10'h201, 10'h101},
                      {32'h33333333, 32'h44444444, 32'h44444444}, 1, 0, 0, 1, 2'd2, 0, MIS_LAT, MIS_INC, MIS_RST, 3);
        vecs[4]  = mk("tmr_nomaj", 1, 8'd9, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'h00000003, 32'h00000002, 32'h00000001}, 1, 0, 0, 1, 2'd3, 0, MIS_LAT, MIS_INC, MIS_RST, 3);
        vecs[5]  = mk("dmr_match", 0, 8'd10, {10'h155, 10'h060, 10'h020}, {10'h155, 10'h061, 10'h025},
                      {32'h0BADF00D, 32'h55AA55AA, 32'h55AA55AA}, 1, 0, 0, 0, 2'd0, 0, 8, 1, 0, 2);
        vecs[6]  = mk("dmr_mis", 0, 8'd11, {10'h155, 10'h060, 10'h020}, {10'h155, 10'h061, 10'h025},
                      {32'h0BADF00D, 32'h00000001, 32'h00000002}, 1, 0, 0, 1, 2'd3, 0, MIS_LAT, MIS_INC, MIS_RST, 2);
        vecs[7]  = mk("dmr_empty", 0, 8'd12, {10'h2AA, 10'h060, 10'h020}, {10'h2AA, 10'h061, 10'h020},
                      {32'h1, 32'h2, 32'h3}, 1, 0, 1, 0, 2'd0, 0, 3, 0, 0, 0);
        vecs[8]  = mk("tmr_empty2", 1, 8'd13, {10'h090, 10'h050, 10'h010}, {10'h090, 10'h051, 10'h011},
                      {32'h1, 32'h1, 32'h1}, 1, 0, 1, 0, 2'd0, 0, 3, 0, 0, 0);
        vecs[9]  = mk("timeout", 1, 8'd14, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'h7, 32'h7, 32'h7}, 0, 0, 0, 0, 2'd0, 1, 22, 1, 0, 3);
        vecs[10] = mk("ack_late", 1, 8'd15, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'h9, 32'h9, 32'h9}, 3, 0, 0, 0, 2'd0, 0, 10, 1, 0, 3);
        vecs[11] = mk("busy_req", 1, 8'd5, {10'h090, 10'h050, 10'h010}, {10'h091, 10'h051, 10'h011},
                      {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, 4, 8, 0, 0, 2'd0, 0, 11, 1, 0, 3);
        cur = vecs[0];

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(r_valid), 0);
        chk("rst.rd_en", 64'(rd_en), 0);
        chk("rst.inc", 64'(inc), 0);
        chk("rst.reset_task", 64'(rst_task), 0);
        chk("rst.task", 64'(cmp_task), 0);
        chk("rst.results", 64'({r_empty, r_mis, r_to, r_core, res_task}), 0);
        reset = 1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted mid-operation (during RD1) abandons it silently.
        @(negedge clk);
        apply_inputs(vecs[0]);
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("midrst.in_rd1", 64'({rd_en, rd_core}), 64'({1'b1, 2'd1}));
        reset = 0;
        #1;
        chk("midrst.rd_en", 64'(rd_en), 0);
        chk("midrst.task", 64'(cmp_task), 0);
        chk("midrst.results", 64'({r_valid, r_empty, r_mis, r_to, r_core, res_task}), 0);
        check_req = 0;
        repeat (3) @(negedge clk);
        chk("midrst.no_pulse", 64'({inc_cnt[7:0], 1'b0, rst_task, r_valid}), 0);
        reset = 1;
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
